// File: rtl/sharpen_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sharpen_frame_ctrl_pkg
// Shared types and constants for the Sobel sharpen frame controller.
//   CNT_W        : width of the pixel/line geometry counters
//   ERR_W        : width of the saturating violation counter
//   PIX_W        : luminance width
//   state_t      : frame-tracking FSM states
//   pix_t        : one stream beat {vsync, href, clken, gray}
//   cnt_sat_inc  : saturating increment for geometry counters
// ---------------------------------------------------------------------------
package sharpen_frame_ctrl_pkg;

    localparam int CNT_W = 11;
    localparam int ERR_W = 8;
    localparam int PIX_W = 8;

    localparam logic [CNT_W-1:0] DEF_HDISP        = 11'd640;
    localparam logic [CNT_W-1:0] DEF_VDISP        = 11'd480;
    localparam int               DEF_PROC_LATENCY = 20;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_ACTIVE     = 2'd2
    } state_t;

    typedef struct packed {
        logic             vsync;
        logic             href;
        logic             clken;
        logic [PIX_W-1:0] gray;
    } pix_t;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sharpen_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// sharpen_frame_ctrl_if
// Video stream bundle (camera-style timing plus 8-bit luminance).
//   vsync : frame valid, high for the whole frame
//   href  : line valid, high for the active pixels of a line
//   clken : pixel strobe
//   gray  : luminance
// Modports: master drives the stream, slave receives it.
// ---------------------------------------------------------------------------
interface sharpen_frame_ctrl_if;
    import sharpen_frame_ctrl_pkg::*;

    logic             vsync;
    logic             href;
    logic             clken;
    logic [PIX_W-1:0] gray;

    modport master (output vsync, href, clken, gray);
    modport slave  (input  vsync, href, clken, gray);

endinterface

// File: rtl/sharpen_frame_ctrl_delay.sv
// ---------------------------------------------------------------------------
// sync_delay_line
// Fixed-depth register pipeline, cleared to zero by reset.
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   i_data : WIDTH-bit input
//   o_data : i_data delayed by DEPTH clock cycles (DEPTH >= 1)
// ---------------------------------------------------------------------------
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/sharpen_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sharpen_frame_ctrl
// Frame-synchronous wrapper control for the Sobel sharpen datapath. Mode
// requests are latched asynchronously to the video and applied only at frame
// start; the output selects either the sharpened stream or a latency-matched
// copy of the raw stream, per frame. Input frame geometry is checked.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   cfg_enable     : requested mode (1 = sharpen, 0 = bypass)
//   cfg_update     : one-cycle pulse capturing cfg_enable as pending request
//   cfg_ack        : one-cycle pulse when a pending request takes effect
//   per_img        : raw input stream (slave)
//   proc_img       : sharpen datapath output stream (slave)
//   post_img       : selected output stream (master), PROC_LATENCY+1 latency
//   active_enable  : mode of the frame currently entering
//   frame_err      : one-cycle pulse on the first geometry violation of a frame
//   err_count      : saturating count of frame_err pulses
// ---------------------------------------------------------------------------
module sharpen_frame_ctrl
    import sharpen_frame_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP    = DEF_HDISP,
    parameter logic [CNT_W-1:0] IMG_VDISP    = DEF_VDISP,
    parameter int               PROC_LATENCY = DEF_PROC_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_enable,
    input  logic                 cfg_update,
    output logic                 cfg_ack,
    sharpen_frame_ctrl_if.slave  per_img,
    sharpen_frame_ctrl_if.slave  proc_img,
    sharpen_frame_ctrl_if.master post_img,
    output logic                 active_enable,
    output logic                 frame_err,
    output logic [ERR_W-1:0]     err_count
);

    state_t           r_state, w_state_nxt;
    logic             r_vsync_d, r_href_d;
    logic             w_vsync_rise, w_vsync_fall, w_href_fall, w_frame_start;
    logic             r_pend_valid, r_pend_val;
    logic             w_pend_valid_eff, w_pend_val_eff;
    logic             r_active_enable, w_active_nxt, r_cfg_ack;
    logic [CNT_W-1:0] r_pix_cnt, r_line_cnt, w_line_nxt;
    logic             w_line_viol, w_frame_viol, w_violation;
    logic             r_err_seen, r_frame_err;
    logic [ERR_W-1:0] r_err_count;
    pix_t             w_byp_in, w_byp_out, w_proc_in, r_post;
    logic             w_mode_tap;

    assign w_vsync_rise  =  per_img.vsync & ~r_vsync_d;
    assign w_vsync_fall  = ~per_img.vsync &  r_vsync_d;
    assign w_href_fall   = ~per_img.href  &  r_href_d;
    assign w_frame_start = (r_state == ST_WAIT_FRAME) && w_vsync_rise;

    // An update landing on the frame-start cycle counts as already pending.
    assign w_pend_valid_eff = r_pend_valid | cfg_update;
    assign w_pend_val_eff   = cfg_update ? cfg_enable : r_pend_val;
    assign w_active_nxt     = (w_frame_start && w_pend_valid_eff) ? w_pend_val_eff
                                                                  : r_active_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_d <= per_img.vsync;
            r_href_d  <= per_img.href;
        end
    end

    // Line count used for the vsync check includes a line ending on the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_line_nxt   = r_line_cnt;
        w_line_viol  = 1'b0;
        w_frame_viol = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!per_img.vsync) w_state_nxt = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (w_vsync_rise) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_href_fall) begin
                    w_line_nxt  = cnt_sat_inc(r_line_cnt);
                    w_line_viol = (r_pix_cnt != IMG_HDISP);
                end
                if (w_vsync_fall) begin
                    w_frame_viol = (w_line_nxt != IMG_VDISP);
                    w_state_nxt  = ST_WAIT_FRAME;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid    <= 1'b0;
            r_pend_val      <= 1'b0;
            r_active_enable <= 1'b0;
            r_cfg_ack       <= 1'b0;
        end else begin
            r_active_enable <= w_active_nxt;
            r_cfg_ack       <= w_frame_start & w_pend_valid_eff;
            if (w_frame_start) begin
                r_pend_valid <= 1'b0;
            end else if (cfg_update) begin
                r_pend_valid <= 1'b1;
                r_pend_val   <= cfg_enable;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (w_frame_start) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (r_state == ST_ACTIVE) begin
            r_pix_cnt  <= per_img.href ? cnt_sat_inc(r_pix_cnt) : '0;
            r_line_cnt <= w_line_nxt;
        end
    end

    assign w_violation = w_line_viol | w_frame_viol;

    // Only the first violation of a frame is reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_seen  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_frame_start) begin
                r_err_seen <= 1'b0;
            end else if (w_violation && !r_err_seen) begin
                r_err_seen  <= 1'b1;
                r_frame_err <= 1'b1;
                r_err_count <= (&r_err_count) ? r_err_count : r_err_count + 1'b1;
            end
        end
    end

    assign w_byp_in  = '{vsync: per_img.vsync, href: per_img.href,
                         clken: per_img.clken, gray: per_img.gray};
    assign w_proc_in = '{vsync: proc_img.vsync, href: proc_img.href,
                         clken: proc_img.clken, gray: proc_img.gray};

    sync_delay_line #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (PROC_LATENCY)
    ) u_bypass_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_byp_in),
        .o_data (w_byp_out)
    );

    // The next-state mode is delayed so the tap flips on the very cycle the
    // frame's first vsync-high beat reaches the output mux.
    sync_delay_line #(
        .WIDTH (1),
        .DEPTH (PROC_LATENCY)
    ) u_mode_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_active_nxt),
        .o_data (w_mode_tap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post <= '0;
        end else begin
            r_post <= w_mode_tap ? w_proc_in : w_byp_out;
        end
    end

    assign post_img.vsync = r_post.vsync;
    assign post_img.href  = r_post.href;
    assign post_img.clken = r_post.clken;
    assign post_img.gray  = r_post.gray;

    assign cfg_ack       = r_cfg_ack;
    assign active_enable = r_active_enable;
    assign frame_err     = r_frame_err;
    assign err_count     = r_err_count;

endmodule
